// File: rtl/flappy_bird_ctrl.sv
// Bird physics/state controller: gravity and flap per Tick, floor/pipe loss, saturating score.
// All outputs are registered and change one Clk after their cause; there is no backpressure.
module flappy_bird_ctrl #(
  parameter int Y_W      = 10,
  parameter int V_W      = 6,
  parameter int S_W      = 8,
  parameter int X_START  = 100,
  parameter int Y_START  = 240,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 464,
  parameter int GRAV     = 1,
  parameter int FLAP_VEL = 8,
  parameter int V_TERM   = 12
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Ack,
  input  logic                  Flap_Button,
  input  logic                  Tick,
  input  logic                  Collide,
  input  logic                  Pass,
  output logic [Y_W-1:0]        YBird,
  output logic [Y_W-1:0]        XBird,
  output logic signed [V_W-1:0] VBird,
  output logic [S_W-1:0]        Score,
  output logic                  q_I,
  output logic                  q_Grav,
  output logic                  q_Flap,
  output logic                  q_UnPress,
  output logic                  q_Lost
);

  typedef enum logic [4:0] {
    S_INI     = 5'b00001,
    S_GRAV    = 5'b00010,
    S_FLAP    = 5'b00100,
    S_UNPRESS = 5'b01000,
    S_LOST    = 5'b10000
  } state_t;

  localparam logic signed [V_W:0]   GRAV_V   = (V_W+1)'(GRAV);
  localparam logic signed [V_W:0]   V_TERM_V = (V_W+1)'(V_TERM);
  localparam logic signed [Y_W+1:0] Y_MIN_S  = (Y_W+2)'(Y_MIN);
  localparam logic signed [Y_W+1:0] Y_MAX_S  = (Y_W+2)'(Y_MAX);
  localparam logic [V_W-1:0]        V_FLAP   = V_W'(-FLAP_VEL);

  state_t                state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic signed [V_W-1:0] v_q, v_d;
  logic [S_W-1:0]        s_q, s_d;

  logic signed [V_W:0]   v_sum, v_step;
  logic signed [Y_W+1:0] v_ext, y_step;
  logic [Y_W-1:0]        y_phys;
  logic [V_W-1:0]        v_phys;
  logic                  phys_floor;
  logic [S_W-1:0]        s_inc;

  // One physics step; one bit of velocity headroom and two of position keep the clamps exact.
  always_comb begin
    v_sum  = $signed({v_q[V_W-1], v_q}) + GRAV_V;
    v_step = (v_sum > V_TERM_V) ? V_TERM_V : v_sum;
    v_ext  = {{(Y_W+1-V_W){v_step[V_W]}}, v_step};
    y_step = $signed({2'b00, y_q}) + v_ext;
    phys_floor = 1'b0;
    if (y_step <= Y_MIN_S) begin
      y_phys = Y_W'(Y_MIN);
      v_phys = '0;
    end else if (y_step >= Y_MAX_S) begin
      y_phys     = Y_W'(Y_MAX);
      v_phys     = '0;
      phys_floor = 1'b1;
    end else begin
      y_phys = y_step[Y_W-1:0];
      v_phys = v_step[V_W-1:0];
    end
    s_inc = (&s_q) ? s_q : s_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    v_d     = v_q;
    s_d     = s_q;
    case (state_q)
      S_INI: begin
        y_d = Y_W'(Y_START);
        v_d = '0;
        if (Start) begin
          state_d = S_GRAV;
          s_d     = '0;
        end
      end
      S_GRAV, S_UNPRESS: begin
        if (Tick) begin
          y_d = y_phys;
          v_d = v_phys;
        end
        if (Pass) s_d = s_inc;
        // Collide beats the floor, and losing beats any button-driven move.
        if (Collide || (Tick && phys_floor)) state_d = S_LOST;
        else if (state_q == S_GRAV && Flap_Button) state_d = S_FLAP;
        else if (state_q == S_UNPRESS && !Flap_Button) state_d = S_GRAV;
      end
      S_FLAP: begin
        v_d     = V_FLAP;
        if (Pass) s_d = s_inc;
        state_d = Collide ? S_LOST : S_UNPRESS;
      end
      S_LOST: begin
        if (Ack) begin
          state_d = S_INI;
          y_d     = Y_W'(Y_START);
          v_d     = '0;
        end
      end
      default: state_d = S_INI;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INI;
      y_q     <= Y_W'(Y_START);
      v_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      v_q     <= v_d;
      s_q     <= s_d;
    end
  end

  assign YBird     = y_q;
  assign XBird     = Y_W'(X_START);
  assign VBird     = v_q;
  assign Score     = s_q;
  assign q_I       = state_q[0];
  assign q_Grav    = state_q[1];
  assign q_Flap    = state_q[2];
  assign q_UnPress = state_q[3];
  assign q_Lost    = state_q[4];

endmodule

// File: tb/tb_flappy_bird_ctrl.sv
// Directed bench for flappy_bird_ctrl; a second instance with a 2-bit score covers saturation.
module tb_flappy_bird_ctrl;

  logic Clk = 1'b0;
  logic Reset, Start, Ack, Flap_Button, Tick, Collide, Pass;
  logic [9:0]        YBird, XBird;
  logic signed [5:0] VBird;
  logic [7:0]        Score;
  logic q_I, q_Grav, q_Flap, q_UnPress, q_Lost;

  logic [9:0]        YBird2, XBird2;
  logic signed [5:0] VBird2;
  logic [1:0]        Score2;
  logic q_I2, q_Grav2, q_Flap2, q_UnPress2, q_Lost2;

  int checks = 0;
  int failures = 0;
  int my, mv, flap_cnt;
  bit mlost;

  always #5 Clk = ~Clk;

  flappy_bird_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Flap_Button(Flap_Button),
    .Tick(Tick), .Collide(Collide), .Pass(Pass),
    .YBird(YBird), .XBird(XBird), .VBird(VBird), .Score(Score),
    .q_I(q_I), .q_Grav(q_Grav), .q_Flap(q_Flap), .q_UnPress(q_UnPress), .q_Lost(q_Lost)
  );

  flappy_bird_ctrl #(.S_W(2)) dut_s2 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Flap_Button(Flap_Button),
    .Tick(Tick), .Collide(Collide), .Pass(Pass),
    .YBird(YBird2), .XBird(XBird2), .VBird(VBird2), .Score(Score2),
    .q_I(q_I2), .q_Grav(q_Grav2), .q_Flap(q_Flap2), .q_UnPress(q_UnPress2), .q_Lost(q_Lost2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Expected physics for one Tick: gravity, terminal clamp, ceiling bump, floor loss.
  task automatic do_tick();
    int ny;
    Tick = 1'b1;
    step();
    Tick = 1'b0;
    mv = (mv + 1 > 12) ? 12 : mv + 1;
    ny = my + mv;
    if (ny <= 0) begin
      my = 0; mv = 0;
    end else if (ny >= 464) begin
      my = 464; mv = 0; mlost = 1'b1;
    end else begin
      my = ny;
    end
    check("tick_y", YBird, my);
    check("tick_v", VBird, mv);
    check("onehot", $countones({q_I, q_Grav, q_Flap, q_UnPress, q_Lost}), 1);
  endtask

  initial begin
    Reset = 1'b1; Start = 0; Ack = 0; Flap_Button = 0; Tick = 0; Collide = 0; Pass = 0;
    #2;
    check("rst_qI", q_I, 1);
    check("rst_y", YBird, 240);
    check("rst_x", XBird, 100);
    check("rst_v", VBird, 0);
    check("rst_score", Score, 0);
    #10 Reset = 1'b0;
    step();

    Ack = 1; Pass = 1; step(); Ack = 0; Pass = 0;
    check("ini_ack_noeffect", q_I, 1);
    check("ini_pass_ignored", Score, 0);

    // Free fall to the floor, Tick every 4 cycles
    Start = 1; step(); Start = 0;
    check("start_grav", q_Grav, 1);
    check("start_y", YBird, 240);
    my = 240; mv = 0; mlost = 0;
    for (int i = 0; i < 40; i++) begin
      do_tick();
      if (mlost) break;
      repeat (3) step();
    end
    check("floor_lost", q_Lost, 1);
    check("floor_y", YBird, 464);
    check("floor_v", VBird, 0);
    Pass = 1; step(); Pass = 0;
    check("lost_frozen_y", YBird, 464);
    Ack = 1; step(); Ack = 0;
    check("ack_ini", q_I, 1);
    check("ack_y", YBird, 240);
    check("ack_v", VBird, 0);

    // Fall 10 ticks to y=295 v=10, then hold the button across several Ticks
    Start = 1; step(); Start = 0;
    my = 240; mv = 0;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      repeat (3) step();
    end
    check("pre_flap_y", YBird, 295);
    check("pre_flap_v", VBird, 10);
    Flap_Button = 1; flap_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      Tick = (c == 1 || c == 2 || c == 6 || c == 10);
      step();
      Tick = 0;
      flap_cnt += int'(q_Flap);
      if (c == 0) begin
        check("flap_state", q_Flap, 1);
        check("flap_y_hold", YBird, 295);
      end
      if (c == 1) begin
        check("flap_tick_dropped_y", YBird, 295);
        check("flap_v", VBird, -8);
        check("unpress_state", q_UnPress, 1);
      end
      if (c == 2) begin check("hold_y1", YBird, 288); check("hold_v1", VBird, -7); end
      if (c == 6) begin check("hold_y2", YBird, 282); check("hold_v2", VBird, -6); end
      if (c == 10) begin check("hold_y3", YBird, 277); check("hold_v3", VBird, -5); end
    end
    check("single_flap", flap_cnt, 1);
    check("held_unpress", q_UnPress, 1);
    Flap_Button = 0; step();
    check("release_grav", q_Grav, 1);

    // Repeated flaps from 277 climb 13 per round; the 22nd round bumps the ceiling
    my = 277; mv = -5;
    for (int r = 0; r < 22; r++) begin
      Flap_Button = 1; step(); Flap_Button = 0;
      step();
      mv = -8;
      check("round_v_flap", VBird, -8);
      do_tick();
      do_tick();
    end
    check("ceil_y", YBird, 1);
    check("ceil_v", VBird, 1);
    check("ceil_not_lost", q_Lost, 0);
    check("ceil_grav", q_Grav, 1);

    // Collide together with a button press
    Flap_Button = 1; Collide = 1; step(); Flap_Button = 0; Collide = 0;
    check("collide_lost", q_Lost, 1);
    check("collide_no_flap", q_Flap, 0);
    step();
    check("collide_still_lost", q_Lost, 1);

    // Score counting and saturation
    Ack = 1; step(); Ack = 0;
    Start = 1; step(); Start = 0;
    for (int k = 0; k < 5; k++) begin
      Pass = 1; step(); Pass = 0;
      check("score8", Score, k + 1);
      check("score2", Score2, (k + 1 > 3) ? 3 : k + 1);
    end
    Collide = 1; step(); Collide = 0;
    Pass = 1; step(); Pass = 0;
    check("lost_score8", Score, 5);
    check("lost_score2", Score2, 3);
    Ack = 1; step(); Ack = 0;
    check("ini_score_held", Score, 5);
    Start = 1; step(); Start = 0;
    check("start_clr8", Score, 0);
    check("start_clr2", Score2, 0);

    // Asynchronous reset from UNPRESS
    Pass = 1; step(); Pass = 0;
    Flap_Button = 1; step(); step();
    my = 240; mv = -8;
    do_tick();
    do_tick();
    check("pre_rst_unpress", q_UnPress, 1);
    check("pre_rst_y", YBird, 227);
    #2 Reset = 1;
    #1;
    check("arst_qI", q_I, 1);
    check("arst_y", YBird, 240);
    check("arst_v", VBird, 0);
    check("arst_score", Score, 0);
    #3 Reset = 0; Flap_Button = 0;
    step();
    check("post_rst_ini", q_I, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
